// File: rtl/reg_cntr_slave.sv
// reg_cntr_slave: leaf register slave holding software RW registers and
// clear-on-read event counters, answering one local_reg_* request at a time
// with a single-cycle acknowledge.

`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_cntr_slave #(
  parameter int          REG_ADDR_BITS = 6,
  parameter int          NUM_SW_REGS   = 4,
  parameter int          NUM_CNTRS     = 4,
  parameter int          INC_WIDTH     = 4,
  parameter logic [31:0] RESET_VAL     = 32'h0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              reg_req,
  input  logic                              reg_rd_wr_L,
  input  logic [REG_ADDR_BITS-1:0]          reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_wr_data,
  output logic                              reg_ack,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_rd_data,
  output logic [NUM_SW_REGS*32-1:0]         sw_regs,
  input  logic [NUM_CNTRS*INC_WIDTH-1:0]    cntr_inc
);

  // The software registers and counters must all fit in the local address space.
  if (NUM_SW_REGS + NUM_CNTRS > 2**REG_ADDR_BITS) begin : g_addr_guard
    $error("reg_cntr_slave: NUM_SW_REGS+NUM_CNTRS exceeds the local address space");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] sw_q   [NUM_SW_REGS];
  logic [31:0] sw_d   [NUM_SW_REGS];
  logic [31:0] cntr_q [NUM_CNTRS];
  logic [31:0] cntr_d [NUM_CNTRS];
  logic [31:0] addr_ext;
  logic        capture;

  // A request is taken (and all its side effects applied) on the edge it is seen in IDLE.
  assign capture  = (state_q == IDLE) && reg_req;
  assign addr_ext = 32'(reg_addr);

  // State register; reset drops the handshake immediately, aborting any transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: ack for one cycle, then wait for the master to release the request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (reg_req) state_d = ACK;
      ACK:     state_d = WAIT;
      WAIT:    if (!reg_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Acknowledge is a pure function of state so it clears asynchronously with reset.
  always_comb begin
    reg_ack = (state_q == ACK);
  end

  // Register file, counter and read-data updates; a read of a counter reloads it with this cycle's increment.
  always_comb begin
    rd_data_d = rd_data_q;
    for (int j = 0; j < NUM_SW_REGS; j++) sw_d[j] = sw_q[j];
    for (int j = 0; j < NUM_CNTRS; j++)
      cntr_d[j] = cntr_q[j] + 32'(cntr_inc[INC_WIDTH*j +: INC_WIDTH]);
    if (capture) begin
      if (reg_rd_wr_L) begin
        rd_data_d = 32'hDEAD_BEEF;
        for (int j = 0; j < NUM_SW_REGS; j++)
          if (addr_ext == 32'(j)) rd_data_d = sw_q[j];
        for (int j = 0; j < NUM_CNTRS; j++)
          if (addr_ext == 32'(NUM_SW_REGS + j)) begin
            rd_data_d = cntr_q[j];
            cntr_d[j] = 32'(cntr_inc[INC_WIDTH*j +: INC_WIDTH]);
          end
      end else begin
        rd_data_d = 32'h0;
        for (int j = 0; j < NUM_SW_REGS; j++)
          if (addr_ext == 32'(j)) sw_d[j] = reg_wr_data;
      end
    end
  end

  // Datapath storage, all returned to known values by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= 32'h0;
      for (int j = 0; j < NUM_SW_REGS; j++) sw_q[j] <= RESET_VAL;
      for (int j = 0; j < NUM_CNTRS; j++) cntr_q[j] <= 32'h0;
    end else begin
      rd_data_q <= rd_data_d;
      for (int j = 0; j < NUM_SW_REGS; j++) sw_q[j] <= sw_d[j];
      for (int j = 0; j < NUM_CNTRS; j++) cntr_q[j] <= cntr_d[j];
    end
  end

  // Flatten the software registers onto the datapath bus and drive read data.
  always_comb begin
    sw_regs = '0;
    for (int j = 0; j < NUM_SW_REGS; j++) sw_regs[32*j +: 32] = sw_q[j];
    reg_rd_data = rd_data_q;
  end

endmodule

// File: tb/tb_reg_cntr_slave.sv
// Testbench for reg_cntr_slave: directed and random register transactions,
// expected read data queued at issue time and checked by an ack monitor.

module tb_reg_cntr_slave;

  localparam int          AB     = 6;
  localparam int          NSW    = 4;
  localparam int          NC     = 4;
  localparam int          IW     = 4;
  localparam int          IW_TOT = NC * IW;
  localparam logic [31:0] RV     = 32'hA5A5_0F0F;

  logic              clk;
  logic              reset_n;
  logic              reg_req;
  logic              reg_rd_wr_L;
  logic [AB-1:0]     reg_addr;
  logic [31:0]       reg_wr_data;
  logic              reg_ack;
  logic [31:0]       reg_rd_data;
  logic [NSW*32-1:0] sw_regs;
  logic [IW_TOT-1:0] cntr_inc;

  reg_cntr_slave #(
    .REG_ADDR_BITS(AB), .NUM_SW_REGS(NSW), .NUM_CNTRS(NC),
    .INC_WIDTH(IW), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_ack(reg_ack),
    .reg_rd_data(reg_rd_data), .sw_regs(sw_regs), .cntr_inc(cntr_inc)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] msw  [NSW];
  logic [31:0] mcnt [NC];
  int          clr_idx  = -1;
  bit          inc_rand = 1'b0;

  // Reference counters: accumulate every edge, reload with the increment when read.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NC; j++) mcnt[j] = 32'h0;
    end else begin
      for (int j = 0; j < NC; j++) begin
        if (j == clr_idx) mcnt[j] = 32'(cntr_inc[IW*j +: IW]);
        else              mcnt[j] = mcnt[j] + 32'(cntr_inc[IW*j +: IW]);
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] r;
    @(negedge clk);
    if (inc_rand) begin
      r = $urandom;
      cntr_inc = r[IW_TOT-1:0];
    end
  endtask

  task automatic checkSwRegs();
    for (int j = 0; j < NSW; j++)
      checkOutput($sformatf("sw_regs[%0d]", j), sw_regs[32*j +: 32], msw[j]);
  endtask

  // Expected response of one access, applying its effect to the reference state.
  function automatic logic [31:0] modelAccess(bit rd, int addr, logic [31:0] data);
    if (addr < NSW) begin
      if (rd) return msw[addr];
      msw[addr] = data;
      return 32'h0;
    end
    if (addr < NSW + NC) begin
      if (rd) begin
        clr_idx = addr - NSW;
        return mcnt[addr - NSW];
      end
      return 32'h0;
    end
    return rd ? 32'hDEAD_BEEF : 32'h0;
  endfunction

  task automatic issue(bit rd, int addr, logic [31:0] data);
    tick();
    reg_req     = 1'b1;
    reg_rd_wr_L = rd;
    reg_addr    = addr[AB-1:0];
    reg_wr_data = data;
    exp_q.push_back(modelAccess(rd, addr, data));
  endtask

  task automatic applyStimulus(bit rd, int addr, logic [31:0] data, int hold);
    int lat;
    bit seen;
    issue(rd, addr, data);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      tick();
      clr_idx = -1;
      lat++;
      seen = reg_ack;
    end
    checkOutput("ack_latency", 32'(lat), 32'd1);
    if (seen) checkSwRegs();
    else if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (hold) tick();
    reg_req = 1'b0;
    repeat (2) tick();
  endtask

  // Ack monitor: each ack must match a queued request, last one cycle, and see req high.
  initial begin
    bit prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_ack === 1'b1) begin
        checkOutput("req_during_ack", 32'(reg_req), 32'd1);
        checkOutput("ack_single_cycle", 32'(prev_ack), 32'd0);
        checkOutput("ack_has_request", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) checkOutput("rd_data", reg_rd_data, exp_q.pop_front());
      end
      prev_ack = reg_ack;
    end
  end

  // Hard stop in case the handshake wedges.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus sequence.
  initial begin
    reset_n     = 1'b0;
    reg_req     = 1'b0;
    reg_rd_wr_L = 1'b1;
    reg_addr    = '0;
    reg_wr_data = '0;
    cntr_inc    = '0;
    for (int j = 0; j < NSW; j++) msw[j] = RV;
    repeat (3) @(negedge clk);
    checkOutput("reset_ack", 32'(reg_ack), 32'd0);
    checkOutput("reset_rd_data", reg_rd_data, 32'h0);
    checkSwRegs();
    reset_n = 1'b1;

    // Write then read back a software register.
    applyStimulus(1'b0, 1, 32'h1234_5678, 1);
    checkOutput("sw1_direct", sw_regs[63:32], 32'h1234_5678);
    applyStimulus(1'b1, 1, 32'h0, 1);

    // Fixed increment on counter 0, read it, then re-read immediately.
    applyStimulus(1'b1, NSW, 32'h0, 1);
    cntr_inc = 16'h0003;
    repeat (10) tick();
    applyStimulus(1'b1, NSW, 32'h0, 1);
    applyStimulus(1'b1, NSW, 32'h0, 1);

    // Long request hold still gives exactly one ack; following request is normal.
    applyStimulus(1'b1, 2, 32'h0, 5);
    applyStimulus(1'b1, 0, 32'h0, 1);

    // Out-of-range and read-only addresses.
    applyStimulus(1'b1, 63, 32'h0, 1);
    applyStimulus(1'b0, 63, 32'hFFFF_FFFF, 1);
    applyStimulus(1'b0, NSW, 32'h0000_0001, 1);
    applyStimulus(1'b1, NSW, 32'h0, 1);

    // Random traffic with random increments.
    inc_rand = 1'b1;
    repeat (60) begin
      int  addr;
      bit  rd;
      logic [31:0] d;
      rd   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, NSW + NC - 1))
                                         : int'($urandom_range(0, 63));
      d    = $urandom;
      applyStimulus(rd, addr, d, int'($urandom_range(1, 4)));
    end

    // Reset while the acknowledge is high.
    applyStimulus(1'b0, 3, 32'hCAFE_F00D, 1);
    issue(1'b1, NSW + 1, 32'h0);
    tick();
    clr_idx = -1;
    checkOutput("pre_reset_ack", 32'(reg_ack), 32'd1);
    #1;
    reset_n = 1'b0;
    for (int j = 0; j < NSW; j++) msw[j] = RV;
    #1;
    checkOutput("async_reset_ack", 32'(reg_ack), 32'd0);
    checkOutput("async_reset_rd_data", reg_rd_data, 32'h0);
    checkSwRegs();
    reg_req  = 1'b0;
    inc_rand = 1'b0;
    cntr_inc = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int j = 0; j < NC; j++) applyStimulus(1'b1, NSW + j, 32'h0, 1);
    inc_rand = 1'b1;
    applyStimulus(1'b0, 2, 32'h0BAD_F00D, 1);
    applyStimulus(1'b1, 2, 32'h0, 2);
    applyStimulus(1'b1, NSW + 2, 32'h0, 1);

    repeat (3) tick();
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
